// File: rtl/gpio_irq_port.sv
// GPIO port: per-bit direction, atomic set/clear/toggle output, synchronised input, edge/level IRQ flags.
// Latency: register writes visible next edge; pin -> o_DIN after SYNC_STAGES edges, pin edge -> IFLAG after SYNC_STAGES+1.
// Backpressure: none; every write strobe is accepted in the cycle it is asserted.
//
// Ports:
//   i_Clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_DD                  write data shared by all strobes
//   i_WEO/WSET/WCLR/WTGL  DOUT load / set / clear / toggle
//   i_WER, i_WIE          DDIR load (1 = input/Z), IE load
//   i_WMODE, i_WPOL       MODE load (1 = edge), POL load (1 = falling/low)
//   i_WICLR               write-1-to-clear of IFLAG
//   IO                    pins, driven from DOUT where DDIR is 0
//   o_DIN, o_DDIR, o_DOUT, o_IFLAG, o_IRQ   status / interrupt outputs
module gpio_irq_port #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2      // legal range 2..4
) (
    input  logic             i_Clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_DD,
    input  logic             i_WEO,
    input  logic             i_WSET,
    input  logic             i_WCLR,
    input  logic             i_WTGL,
    input  logic             i_WER,
    input  logic             i_WIE,
    input  logic             i_WMODE,
    input  logic             i_WPOL,
    input  logic             i_WICLR,
    inout  wire  [WIDTH-1:0] IO,
    output logic [WIDTH-1:0] o_DIN,
    output logic [WIDTH-1:0] o_DDIR,
    output logic [WIDTH-1:0] o_DOUT,
    output logic [WIDTH-1:0] o_IFLAG,
    output logic             o_IRQ
);

    logic [WIDTH-1:0] dout_q, ddir_q, ie_q, mode_q, pol_q, iflag_q, din_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] dout_d, iflag_d;
    logic [WIDTH-1:0] set_msk, clr_msk, tgl_msk, iclr_msk;
    logic [WIDTH-1:0] din, rise, fall, edge_evt, lvl_evt, evt;

    // Set, then clear, then toggle; a full load overrides all three.
    assign set_msk  = i_WSET  ? i_DD : '0;
    assign clr_msk  = i_WCLR  ? i_DD : '0;
    assign tgl_msk  = i_WTGL  ? i_DD : '0;
    assign iclr_msk = i_WICLR ? i_DD : '0;

    always_comb begin
        dout_d = ((dout_q | set_msk) & ~clr_msk) ^ tgl_msk;
        if (i_WEO) begin
            dout_d = i_DD;
        end
    end

    // Event detection works on the synchronised value and its one-cycle-old copy.
    assign din      = sync_q[SYNC_STAGES-1];
    assign rise     = ~din_q & din;
    assign fall     = din_q & ~din;
    assign edge_evt = (rise & ~pol_q) | (fall & pol_q);
    assign lvl_evt  = din ^ pol_q;
    assign evt      = (mode_q & edge_evt) | (~mode_q & lvl_evt);

    // A new event wins over a same-cycle clear, so an active level keeps re-arming its flag.
    assign iflag_d  = evt | (iflag_q & ~iclr_msk);

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dout_q  <= '0;
            ddir_q  <= '0;
            ie_q    <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            iflag_q <= '0;
            din_q   <= '0;
        end else begin
            dout_q  <= dout_d;
            iflag_q <= iflag_d;
            din_q   <= din;
            if (i_WER)   ddir_q <= i_DD;
            if (i_WIE)   ie_q   <= i_DD;
            if (i_WMODE) mode_q <= i_DD;
            if (i_WPOL)  pol_q  <= i_DD;
        end
    end

    // Metastability chain; stage 0 is the only flop that sees the raw pin.
    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= IO;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        assign IO[g] = ddir_q[g] ? 1'bz : dout_q[g];
    end

    assign o_DIN   = din;
    assign o_DDIR  = ddir_q;
    assign o_DOUT  = dout_q;
    assign o_IFLAG = iflag_q;
    assign o_IRQ   = |(iflag_q & ie_q);

endmodule

// File: tb/tb_gpio_irq_port.sv
module tb_gpio_irq_port;

    localparam logic [8:0] M_EO   = 9'h001;
    localparam logic [8:0] M_SET  = 9'h002;
    localparam logic [8:0] M_CLR  = 9'h004;
    localparam logic [8:0] M_TGL  = 9'h008;
    localparam logic [8:0] M_ER   = 9'h010;
    localparam logic [8:0] M_IE   = 9'h020;
    localparam logic [8:0] M_MODE = 9'h040;
    localparam logic [8:0] M_POL  = 9'h080;
    localparam logic [8:0] M_ICLR = 9'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_errors = 0;

    // 32-bit instance
    logic [8:0]  st;
    logic [31:0] dd, pin_en, pin_val;
    wire  [31:0] io;
    logic [31:0] din, ddir, dout, iflag;
    logic        irq;

    // 8-bit, 3-stage instance
    logic [8:0]  st8;
    logic [7:0]  dd8, pin_en8, pin_val8;
    wire  [7:0]  io8;
    logic [7:0]  din8, ddir8, dout8, iflag8;
    logic        irq8;

    // reference model state for the 8-bit instance
    logic [7:0]  m_dout, m_ddir, m_ie, m_mode, m_pol, m_iflag, m_din_q, m_pin, m_evt, m_s0, m_s1, m_s2;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 32; g++) begin : g_drv
        assign io[g] = pin_en[g] ? pin_val[g] : 1'bz;
    end
    for (genvar g = 0; g < 8; g++) begin : g_drv8
        assign io8[g] = pin_en8[g] ? pin_val8[g] : 1'bz;
    end

    gpio_irq_port #(.WIDTH(32), .SYNC_STAGES(2)) u_dut (
        .i_Clk(clk), .i_rst_n(rst_n), .i_DD(dd),
        .i_WEO(st[0]), .i_WSET(st[1]), .i_WCLR(st[2]), .i_WTGL(st[3]),
        .i_WER(st[4]), .i_WIE(st[5]), .i_WMODE(st[6]), .i_WPOL(st[7]), .i_WICLR(st[8]),
        .IO(io), .o_DIN(din), .o_DDIR(ddir), .o_DOUT(dout), .o_IFLAG(iflag), .o_IRQ(irq)
    );

    gpio_irq_port #(.WIDTH(8), .SYNC_STAGES(3)) u_dut8 (
        .i_Clk(clk), .i_rst_n(rst_n), .i_DD(dd8),
        .i_WEO(st8[0]), .i_WSET(st8[1]), .i_WCLR(st8[2]), .i_WTGL(st8[3]),
        .i_WER(st8[4]), .i_WIE(st8[5]), .i_WMODE(st8[6]), .i_WPOL(st8[7]), .i_WICLR(st8[8]),
        .IO(io8), .o_DIN(din8), .o_DDIR(ddir8), .o_DOUT(dout8), .o_IFLAG(iflag8), .o_IRQ(irq8)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one-cycle write pulse on the selected strobes of either instance
    task automatic wr(input bit b8, input logic [8:0] msk, input logic [31:0] d);
        if (b8) begin st8 = msk; dd8 = d[7:0]; end
        else    begin st  = msk; dd  = d;      end
        tick(1);
        st = '0; st8 = '0;
    endtask

    initial begin
        rst_n = 1'b1; st = '0; st8 = '0; dd = '0; dd8 = '0;
        pin_en = '0; pin_val = '0; pin_en8 = '0; pin_val8 = '0;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_dout", dout, 32'h0);
        check_val("rst_io", io, 32'h0);
        check_val("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // output writes, DDIR=0
        wr(0, M_EO, 32'h0000_00F0);
        check_val("t2_weo", dout, 32'h0000_00F0);
        wr(0, M_SET, 32'h1);
        wr(0, M_CLR, 32'h10);
        wr(0, M_TGL, 32'h300);
        check_val("t2_sct_seq", dout, 32'h0000_03E1);
        check_val("t2_io_drive", io, 32'h0000_03E1);
        tick(2);
        check_val("t2_readback", din, 32'h0000_03E1);
        wr(0, M_SET | M_CLR | M_TGL, 32'h0F);    // ((3E1|F)&~F)^F
        check_val("t2_sct_same", dout, 32'h0000_03EF);
        wr(0, M_EO | M_SET, 32'h5);
        check_val("t2_weo_wins", dout, 32'h5);

        // input path and edge flag latency
        wr(0, M_ER, 32'hFFFF_FFFF);
        pin_en = 32'hFFFF_FFFF; pin_val = '0;
        wr(0, M_MODE, 32'h8);
        tick(3);
        wr(0, M_ICLR, 32'hFFFF_FFFF);
        check_val("t3_flags_clr", iflag, 32'h0);
        pin_val[3] = 1'b1;
        tick(1);
        check_val("t3_din_e1", {31'h0, din[3]}, 32'h0);
        tick(1);
        check_val("t3_din_e2", {31'h0, din[3]}, 32'h1);
        check_val("t3_flag_e2", iflag, 32'h0);
        tick(1);
        check_val("t3_flag_e3", iflag, 32'h8);
        check_val("t3_irq_masked", {31'h0, irq}, 32'h0);
        wr(0, M_IE, 32'h8);
        check_val("t3_irq_on", {31'h0, irq}, 32'h1);

        // falling-edge polarity and W1C
        wr(0, M_MODE, 32'hFFFF_FFFF);
        wr(0, M_POL, 32'h80);
        wr(0, M_ICLR, 32'hFFFF_FFFF);
        check_val("t4_clr_all", iflag, 32'h0);
        check_val("t4_irq_off", {31'h0, irq}, 32'h0);
        pin_val[7] = 1'b1;
        tick(4);
        check_val("t4_rise_ignored", iflag, 32'h0);
        pin_val[7] = 1'b0;
        tick(3);
        check_val("t4_fall_flag", iflag, 32'h80);
        wr(0, M_ICLR, 32'h80);
        check_val("t4_w1c", iflag, 32'h0);
        pin_val[7] = 1'b1;
        tick(4);
        pin_val[7] = 1'b0;
        tick(2);
        wr(0, M_ICLR, 32'h80);                 // clear on the same edge as the new event
        check_val("t4_set_beats_clr", iflag, 32'h80);
        tick(1);
        check_val("t4_sticky", iflag, 32'h80);
        wr(0, M_ICLR, 32'h80);
        check_val("t4_w1c2", iflag, 32'h0);

        // level mode on bit 0
        wr(0, M_MODE, 32'hFFFF_FFFE);
        pin_val[0] = 1'b1;
        tick(3);
        check_val("t5_level_flag", iflag, 32'h1);
        wr(0, M_ICLR, 32'h1);
        check_val("t5_clr_no_stick", iflag, 32'h1);
        check_val("t5_irq_mask", {31'h0, irq}, 32'h0);
        pin_val[0] = 1'b0;
        tick(3);
        wr(0, M_ICLR, 32'h1);
        check_val("t5_clr_sticks", iflag, 32'h0);

        // reset in the middle of activity
        pin_val[0] = 1'b1;
        tick(3);
        wr(0, M_IE, 32'h1);
        wr(0, M_EO, 32'hA5A5_A5A5);
        check_val("t1_pre_irq", {31'h0, irq}, 32'h1);
        pin_en = '0;
        rst_n  = 1'b0;
        #2;
        check_val("t1_dout", dout, 32'h0);
        check_val("t1_ddir", ddir, 32'h0);
        check_val("t1_iflag", iflag, 32'h0);
        check_val("t1_io", io, 32'h0);
        check_val("t1_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // 8-bit, 3-stage instance
        wr(1, M_EO, 32'hF0);
        wr(1, M_SET, 32'h1);
        wr(1, M_CLR, 32'h10);
        wr(1, M_TGL, 32'h300);
        check_val("t6_sct", {24'h0, dout8}, 32'hE1);
        wr(1, M_EO | M_SET, 32'h5);
        check_val("t6_weo_wins", {24'h0, dout8}, 32'h5);
        wr(1, M_ER, 32'hFF);
        pin_en8 = 8'hFF; pin_val8 = '0;
        wr(1, M_MODE, 32'h8);
        tick(4);
        wr(1, M_ICLR, 32'hFF);
        check_val("t6_flags_clr", {24'h0, iflag8}, 32'h0);
        pin_val8[3] = 1'b1;
        tick(2);
        check_val("t6_din_e2", {31'h0, din8[3]}, 32'h0);
        tick(1);
        check_val("t6_din_e3", {31'h0, din8[3]}, 32'h1);
        check_val("t6_flag_e3", {24'h0, iflag8}, 32'h0);
        tick(1);
        check_val("t6_flag_e4", {24'h0, iflag8}, 32'h8);

        // randomised strobes against a behavioural model
        pin_en8 = '0;
        rst_n   = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        m_dout = '0; m_ddir = '0; m_ie = '0; m_mode = '0; m_pol = '0;
        m_iflag = '0; m_din_q = '0; m_s0 = '0; m_s1 = '0; m_s2 = '0;
        tick(1);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < 9; b++) st8[b] = ($urandom_range(0, 3) == 0);
            st8[4] = ($urandom_range(0, 15) == 0);
            dd8 = 8'($urandom);
            if ($urandom_range(0, 1) == 0) pin_val8 = pin_val8 ^ (8'($urandom) & 8'($urandom));

            m_pin = (m_ddir & pin_val8) | (~m_ddir & m_dout);
            for (int b = 0; b < 8; b++) begin
                if (m_mode[b]) m_evt[b] = m_pol[b] ? (m_din_q[b] && !m_s2[b]) : (!m_din_q[b] && m_s2[b]);
                else           m_evt[b] = m_s2[b] != m_pol[b];
            end
            m_iflag = m_evt | (m_iflag & ~(st8[8] ? dd8 : 8'h0));
            m_din_q = m_s2;
            m_s2 = m_s1; m_s1 = m_s0; m_s0 = m_pin;
            if (st8[0]) m_dout = dd8;
            else begin
                if (st8[1]) m_dout = m_dout | dd8;
                if (st8[2]) m_dout = m_dout & ~dd8;
                if (st8[3]) m_dout = m_dout ^ dd8;
            end
            if (st8[4]) m_ddir = dd8;
            if (st8[5]) m_ie   = dd8;
            if (st8[6]) m_mode = dd8;
            if (st8[7]) m_pol  = dd8;

            tick(1);
            pin_en8 = m_ddir;
            check_val("rnd_regs", {dout8, ddir8, din8, iflag8}, {m_dout, m_ddir, m_s2, m_iflag});
            check_val("rnd_irq", {31'h0, irq8}, {31'h0, |(m_iflag & m_ie)});
        end
        st8 = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
